fetch_unit: RTL and testbench

- Instruction-supply end of the 9-bit instruction interface: produces the instruction word that the control decoder consumes each cycle.
- Owns the program counter and drives the instruction ROM address.
- Applies sequential, branch (absolute or PC-relative) and stall updates.
- Detects the halt opcode and reports Done to the testbench/top level.

---
 rtl/fetch_unit_if.sv | 42 ++++
 rtl/fetch_unit.sv | 100 ++++++++++
 tb/tb_fetch_unit.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-fetch bus between the fetch unit and its
// surroundings (control decoder, instruction ROM, top level).
//   master : decoder/top side -- drives Start, Stall, branch controls and
//            the ROM read data InstrIn; observes fetch outputs.
//   slave  : fetch unit side -- drives InstrAddr, Instruction, InstrValid,
//            Busy, Done (and the performance counters when
//            FETCH_PERF_CNT_EN is defined).
interface fetch_unit_if #(
    parameter int PC_W = 10
);
    logic            Start;
    logic            Stall;
    logic            BranchEn;
    logic            BranchRel;
    logic [PC_W-1:0] BranchTarget;
    logic [8:0]      InstrIn;
    logic [PC_W-1:0] InstrAddr;
    logic [8:0]      Instruction;
    logic            InstrValid;
    logic            Busy;
    logic            Done;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0]     InstrCount;
    logic [15:0]     CycleCount;
`endif

    modport master (
`ifdef FETCH_PERF_CNT_EN
        input  InstrCount, CycleCount,
`endif
        output Start, Stall, BranchEn, BranchRel, BranchTarget, InstrIn,
        input  InstrAddr, Instruction, InstrValid, Busy, Done
    );

    modport slave (
`ifdef FETCH_PERF_CNT_EN
        output InstrCount, CycleCount,
`endif
        input  Start, Stall, BranchEn, BranchRel, BranchTarget, InstrIn,
        output InstrAddr, Instruction, InstrValid, Busy, Done
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: owns the program counter, addresses the instruction ROM and
// presents the fetched word to the control decoder. Handles sequential
// advance, absolute/PC-relative branches, stalls and the halt opcode.
// Ports:
//   CLK   - system clock, rising edge
//   Reset - asynchronous, active-high reset
//   bus   - fetch_unit_if.slave (Start, Stall, BranchEn, BranchRel,
//           BranchTarget, InstrIn in; InstrAddr, Instruction, InstrValid,
//           Busy, Done out)
// Optional: define FETCH_PERF_CNT_EN to add saturating 16-bit InstrCount
// and CycleCount outputs on the interface.
module fetch_unit #(
    parameter int              PC_W       = 10,
    parameter logic [PC_W-1:0] START_ADDR = '0,
    parameter logic [8:0]      HALT_OP    = 9'h1FF,
    parameter logic [8:0]      NOP_OP     = 9'h100
) (
    input  logic        CLK,
    input  logic        Reset,
    fetch_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt;
    logic            start_acc;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            pc    <= START_ADDR;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        start_acc = 1'b0;
        case (state)
            IDLE, HALT: begin
                if (bus.Start) begin
                    state_nxt = RUN;
                    pc_nxt    = START_ADDR;
                    start_acc = 1'b1;
                end
            end
            RUN: begin
                // Halt beats stall and branch; a stalled cycle drops any branch.
                if (bus.InstrIn == HALT_OP) begin
                    state_nxt = HALT;
                end else if (!bus.Stall) begin
                    if (bus.BranchEn) begin
                        // Offset is PC_W wide, so a modulo-2^PC_W add is the
                        // sign-extended relative branch.
                        pc_nxt = bus.BranchRel ? pc + bus.BranchTarget
                                               : bus.BranchTarget;
                    end else begin
                        pc_nxt = pc + PC_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.InstrAddr   = pc;
    assign bus.Instruction = (state == RUN) ? bus.InstrIn : NOP_OP;
    assign bus.InstrValid  = (state == RUN);
    assign bus.Busy        = (state == RUN);
    assign bus.Done        = (state == HALT);

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] instr_cnt, cycle_cnt;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            instr_cnt <= '0;
            cycle_cnt <= '0;
        end else if (start_acc) begin
            instr_cnt <= '0;
            cycle_cnt <= '0;
        end else if (state == RUN) begin
            if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 16'd1;
            if (!bus.Stall && instr_cnt != '1) instr_cnt <= instr_cnt + 16'd1;
        end
    end

    assign bus.InstrCount = instr_cnt;
    assign bus.CycleCount = cycle_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic CLK = 1'b0;
    logic Reset;
    always #5 CLK = ~CLK;

    fetch_unit_if #(.PC_W(10)) bus ();

    fetch_unit #(
        .PC_W       (10),
        .START_ADDR (10'd0),
        .HALT_OP    (9'h1FF),
        .NOP_OP     (9'h100)
    ) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    // Instruction ROM: asynchronous read of the current address.
    logic [8:0] rom [0:1023];
    assign bus.InstrIn = rom[bus.InstrAddr];

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Behavioural model: running flag, done flag, pc, counters.
    bit         m_run  = 0;
    bit         m_done = 0;
    logic [9:0] m_pc   = '0;
    int         m_cyc  = 0;
    int         m_ins  = 0;

    always @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            m_run <= 0; m_done <= 0; m_pc <= '0; m_cyc <= 0; m_ins <= 0;
        end else if (m_run) begin
            m_cyc <= (m_cyc == 65535) ? m_cyc : m_cyc + 1;
            if (!bus.Stall) m_ins <= (m_ins == 65535) ? m_ins : m_ins + 1;
            if (rom[m_pc] == 9'h1FF) begin
                m_run  <= 0;
                m_done <= 1;
            end else if (!bus.Stall) begin
                if (bus.BranchEn)
                    m_pc <= bus.BranchRel ? 10'(m_pc + bus.BranchTarget) : bus.BranchTarget;
                else
                    m_pc <= 10'(m_pc + 10'd1);
            end
        end else if (bus.Start) begin
            m_run <= 1; m_done <= 0; m_pc <= '0; m_cyc <= 0; m_ins <= 0;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("addr",  bus.InstrAddr, m_pc);
            chk("instr", bus.Instruction, m_run ? rom[m_pc] : 9'h100);
            chk("valid", bus.InstrValid, m_run);
            chk("busy",  bus.Busy, m_run);
            chk("done",  bus.Done, m_done);
`ifdef FETCH_PERF_CNT_EN
            chk("cyccnt", bus.CycleCount, m_cyc);
            chk("inscnt", bus.InstrCount, m_ins);
`endif
        end
    end

    task automatic drv(input bit st, input bit sl, input bit be, input bit br,
                       input logic [9:0] tg);
        #1;
        bus.Start = st; bus.Stall = sl; bus.BranchEn = be;
        bus.BranchRel = br; bus.BranchTarget = tg;
        @(negedge CLK);
    endtask

    task automatic chk_idle(input string nm, input logic [9:0] addr, input bit done);
        chk({nm, "_addr"},  bus.InstrAddr, addr);
        chk({nm, "_instr"}, bus.Instruction, 9'h100);
        chk({nm, "_valid"}, bus.InstrValid, 1'b0);
        chk({nm, "_busy"},  bus.Busy, 1'b0);
        chk({nm, "_done"},  bus.Done, done);
    endtask

    task automatic pulse_reset();
        #1 Reset = 1'b1;
        @(negedge CLK);
        #1 Reset = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        Reset = 1'b1;
        bus.Start = 0; bus.Stall = 0; bus.BranchEn = 0; bus.BranchRel = 0;
        bus.BranchTarget = '0;
        for (int i = 0; i < 1024; i++) rom[i] = 9'($urandom_range(0, 9'h1FE));
        rom[0] = 9'h001; rom[1] = 9'h002; rom[2] = 9'h003; rom[3] = 9'h1FF;
        repeat (2) @(negedge CLK);
        chk_idle("rst", 10'd0, 1'b0);
        #1 Reset = 1'b0;
        chk_en = 1;

        // Short program ending in halt.
        drv(1, 0, 0, 0, 0);
        chk("p_a0", bus.InstrAddr, 10'd0);
        chk("p_i0", bus.Instruction, 9'h001);
        chk("p_b0", bus.Busy, 1'b1);
        drv(0, 0, 0, 0, 0); chk("p_a1", bus.InstrAddr, 10'd1);
        drv(0, 0, 0, 0, 0); chk("p_a2", bus.InstrAddr, 10'd2);
        drv(0, 0, 0, 0, 0); chk("p_a3", bus.InstrAddr, 10'd3);
        chk("p_i3", bus.Instruction, 9'h1FF);
        drv(0, 0, 0, 0, 0); chk_idle("halt", 10'd3, 1'b1);
        drv(0, 1, 1, 0, 10'd9); chk_idle("halt2", 10'd3, 1'b1);

        // Restart from HALT, then branches, stalls and wrap.
        rom[3] = 9'h004;
        drv(1, 0, 0, 0, 0);
        chk("rs_a", bus.InstrAddr, 10'd0);
        chk("rs_d", bus.Done, 1'b0);
        repeat (5) drv(0, 0, 0, 0, 0);
        chk("seq5", bus.InstrAddr, 10'd5);
        drv(0, 0, 1, 0, 10'd40);    chk("br_abs", bus.InstrAddr, 10'd40);
        drv(0, 0, 1, 1, 10'h3FE);   chk("br_rel", bus.InstrAddr, 10'd38);
        drv(0, 0, 1, 0, 10'd7);     chk("br_7", bus.InstrAddr, 10'd7);
        for (int i = 0; i < 3; i++) begin
            drv(0, 1, 1, 0, 10'd40); chk("stall", bus.InstrAddr, 10'd7);
        end
        drv(0, 0, 0, 0, 0);         chk("unstall", bus.InstrAddr, 10'd8);
        drv(0, 0, 1, 0, 10'd1023);  chk("br_top", bus.InstrAddr, 10'd1023);
        drv(0, 0, 0, 0, 0);         chk("wrap", bus.InstrAddr, 10'd0);
        drv(0, 0, 1, 0, 10'd2);     chk("br_2", bus.InstrAddr, 10'd2);
        drv(0, 0, 1, 1, 10'h3FC);   chk("rel_wrap", bus.InstrAddr, 10'd1022);
        drv(0, 0, 1, 0, 10'd12);    chk("br_12", bus.InstrAddr, 10'd12);
        drv(0, 0, 0, 0, 0);         chk("seq13", bus.InstrAddr, 10'd13);

        // Asynchronous reset mid-cycle, then Start coincident with Reset.
        #2 Reset = 1'b1;
        #1 chk_idle("async_rst", 10'd0, 1'b0);
        bus.Start = 1'b1;
        @(negedge CLK);
        #1 Reset = 1'b0; bus.Start = 1'b0;
        @(negedge CLK);
        chk_idle("rst_start", 10'd0, 1'b0);

        // Randomised run against the model.
        for (int i = 0; i < 1024; i++)
            rom[i] = ($urandom_range(0, 31) == 0) ? 9'h1FF : 9'($urandom_range(0, 9'h1FE));
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset();
            end else begin
                drv($urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                    10'($urandom_range(0, 1023)));
            end
        end

`ifdef FETCH_PERF_CNT_EN
        // Five fetches (last is halt) with two stall cycles.
        pulse_reset();
        rom[0] = 9'h010; rom[1] = 9'h011; rom[2] = 9'h012; rom[3] = 9'h013;
        rom[4] = 9'h1FF;
        drv(1, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0);
        drv(0, 1, 0, 0, 0);
        drv(0, 1, 0, 0, 0);
        repeat (4) drv(0, 0, 0, 0, 0);
        chk("perf_done", bus.Done, 1'b1);
        chk("perf_cyc", bus.CycleCount, 16'd7);
        chk("perf_ins", bus.InstrCount, 16'd5);
        repeat (3) drv(0, 1, 0, 0, 0);
        chk("perf_cyc_hold", bus.CycleCount, 16'd7);
        chk("perf_ins_hold", bus.InstrCount, 16'd5);
`endif

        drv(0, 0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
